// File: rtl/matrix_pkg.sv
// Shared constants and types for the ASCII matrix parser: character codes,
// parser states, error codes and dimension limits.
package matrix_pkg;

  localparam int MAX_DIM = 5;
  localparam int idx_w   = 5;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BAD_CHAR = 2'b01;
  localparam logic [1:0] ERR_DIM      = 2'b10;
  localparam logic [1:0] ERR_OVF      = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    GET_ROWS,
    GET_COLS,
    GET_ELEM,
    FINISH,
    FAIL
  } parse_state_t;

endpackage

// File: rtl/ascii_dec_accum.sv
// Byte classifier plus saturating decimal accumulator for one ASCII token.
// Classification and overflow are combinational on the current byte.
module ascii_dec_accum #(
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       strobe,
  input  logic [7:0] data,
  output logic       is_digit,
  output logic       is_sep,
  output logic       is_bad,
  output logic [8:0] value,
  output logic       in_tok,
  output logic       overflow
);
  import matrix_pkg::*;

  localparam logic [12:0] ELEM_MAX = 13'((1 << DATA_W) - 1);

  logic [3:0]  digit;
  logic [12:0] sum_next;
  logic [8:0]  acc_next;

  always_comb begin
    is_digit = (data >= ASCII_0) && (data <= ASCII_9);
    is_sep   = (data == ASCII_SP) || (data == ASCII_COMMA) ||
               (data == ASCII_CR) || (data == ASCII_LF);
    is_bad   = !is_digit && !is_sep;
    // ASCII digits carry their value in the low nibble.
    digit    = data[3:0];
    sum_next = {4'b0, value} * 13'd10 + {9'b0, digit};
    acc_next = (sum_next > 13'd511) ? 9'd511 : sum_next[8:0];
    overflow = strobe && is_digit && (sum_next > ELEM_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value  <= '0;
      in_tok <= 1'b0;
    end else if (strobe) begin
      if (is_digit) begin
        value  <= acc_next;
        in_tok <= 1'b1;
      end else if (is_sep) begin
        value  <= '0;
        in_tok <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/matrix_uart_parser.sv
// Parses "rows cols e0 e1 ..." from a UART byte stream and issues one
// matrix-store write per element; reports dimensions or a coded error.
module matrix_uart_parser #(
  parameter int MAX_DIM = matrix_pkg::MAX_DIM,
  parameter int DATA_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         uart_rx_done,
  input  logic [7:0]                   uart_rx_data,
  output logic                         wr_en,
  output logic [matrix_pkg::idx_w-1:0] wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic [2:0]                   rows,
  output logic [2:0]                   cols,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   err_code
);
  import matrix_pkg::*;

  parse_state_t     state;
  logic [idx_w-1:0] elem_cnt;
  logic [idx_w-1:0] total;
  logic [idx_w-1:0] cnt_inc;

  logic       start_ok;
  logic       strobe;
  logic       is_digit;
  logic       is_sep;
  logic       is_bad;
  logic       in_tok;
  logic       overflow;
  logic [8:0] acc;
  logic       dim_ok;
  logic       fail_req;
  logic [1:0] fail_code;
  logic       commit;

  // FAIL is already non-busy, so a start there is honoured like in IDLE.
  assign start_ok = start && ((state == IDLE) || (state == FAIL));
  assign strobe   = uart_rx_done && (state inside {GET_ROWS, GET_COLS, GET_ELEM});
  assign dim_ok   = (acc >= 9'd1) && (acc <= 9'(MAX_DIM));
  assign cnt_inc  = elem_cnt + 5'd1;

  ascii_dec_accum #(.DATA_W(DATA_W)) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .strobe   (strobe),
    .data     (uart_rx_data),
    .is_digit (is_digit),
    .is_sep   (is_sep),
    .is_bad   (is_bad),
    .value    (acc),
    .in_tok   (in_tok),
    .overflow (overflow)
  );

  always_comb begin
    fail_req  = 1'b0;
    fail_code = ERR_NONE;
    commit    = 1'b0;
    if (strobe) begin
      if (is_bad) begin
        fail_req  = 1'b1;
        fail_code = ERR_BAD_CHAR;
      end else if (is_digit) begin
        if (overflow) begin
          fail_req  = 1'b1;
          fail_code = ERR_OVF;
        end
      end else if (is_sep && in_tok) begin
        if ((state != GET_ELEM) && !dim_ok) begin
          fail_req  = 1'b1;
          fail_code = ERR_DIM;
        end else begin
          commit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rows     <= '0;
      cols     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
      elem_cnt <= '0;
      total    <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE, FAIL: begin
          if (start_ok) begin
            state    <= GET_ROWS;
            busy     <= 1'b1;
            err_code <= ERR_NONE;
            rows     <= '0;
            cols     <= '0;
            elem_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GET_ROWS, GET_COLS, GET_ELEM: begin
          if (fail_req) begin
            state    <= FAIL;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= fail_code;
          end else if (commit) begin
            case (state)
              GET_ROWS: begin
                rows  <= acc[2:0];
                state <= GET_COLS;
              end
              GET_COLS: begin
                cols  <= acc[2:0];
                total <= {2'b0, rows} * {2'b0, acc[2:0]};
                state <= GET_ELEM;
              end
              default: begin
                wr_en    <= 1'b1;
                wr_addr  <= elem_cnt;
                wr_data  <= acc[DATA_W-1:0];
                elem_cnt <= cnt_inc;
                if (cnt_inc == total) state <= FINISH;
              end
            endcase
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_uart_parser.sv
// Randomised scoreboard bench for matrix_uart_parser: a string-level parser
// model predicts writes and outcomes, a negedge monitor pops and compares.
module tb_matrix_uart_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rows;
  logic [2:0] cols;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  matrix_uart_parser #(.MAX_DIM(5), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .uart_rx_done (uart_rx_done),
    .uart_rx_data (uart_rx_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rows         (rows),
    .cols         (cols),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int bidx; } wr_exp_t;
  typedef struct { bit is_err; int code; int r; int c; int bidx; int delay; } res_exp_t;

  wr_exp_t  wq[$];
  res_exp_t rq[$];
  int strobe_cyc [0:2047];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_err(input int code, input int idx);
    res_exp_t r;
    r.is_err = 1'b1; r.code = code; r.r = 0; r.c = 0; r.bidx = idx; r.delay = 1;
    rq.push_back(r);
  endtask

  // Token-level reference: integers, token count, early exit on the first outcome.
  task automatic model(input string s);
    int ntok = 0;
    int val = 0;
    int r = 0;
    int c = 0;
    bit tok = 0;
    wr_exp_t w;
    res_exp_t res;
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] ch;
      ch = s[i];
      if (ch >= 8'h30 && ch <= 8'h39) begin
        val = val * 10 + int'(ch - 8'h30);
        tok = 1;
        if (val > 255) begin push_err(3, i); return; end
      end else if (ch == 8'h20 || ch == 8'h2C || ch == 8'h0D || ch == 8'h0A) begin
        if (tok) begin
          if (ntok < 2) begin
            if (val < 1 || val > 5) begin push_err(2, i); return; end
            if (ntok == 0) r = val; else c = val;
          end else begin
            w.addr = ntok - 2; w.data = val; w.bidx = i;
            wq.push_back(w);
            if (ntok - 2 == r * c - 1) begin
              res.is_err = 1'b0; res.code = 0; res.r = r; res.c = c; res.bidx = i; res.delay = 2;
              rq.push_back(res);
              return;
            end
          end
          ntok++;
          val = 0;
          tok = 0;
        end
      end else begin
        push_err(1, i);
        return;
      end
    end
  endtask

  task automatic do_start(input bit with_byte, input logic [7:0] b);
    start = 1'b1; uart_rx_done = with_byte; uart_rx_data = b;
    tick();
    start = 1'b0; uart_rx_done = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      uart_rx_done = 1'b1;
      uart_rx_data = s[i];
      strobe_cyc[i] = cyc;
      tick();
      uart_rx_done = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((wq.size() != 0 || rq.size() != 0) && n < 60) begin tick(); n++; end
    repeat (3) tick();
    check("drain", wq.size() + rq.size(), 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_case(input string s, input bit dummy);
    model(s);
    do_start(dummy, 8'h33);
    send_str(s);
    wait_drain();
  endtask

  function automatic string num_str(input int v);
    string z = "";
    if ($urandom_range(0, 3) == 0) z = ($urandom_range(0, 1) == 1) ? "0" : "00";
    return {z, $sformatf("%0d", v)};
  endfunction

  function automatic string sep_str();
    string s = "";
    int n = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0: s = {s, " "};
        1: s = {s, ","};
        2: s = {s, "\015"};
        default: s = {s, "\n"};
      endcase
    end
    return s;
  endfunction

  function automatic string gen_case();
    string s = "";
    string bad = "x-.;A/:";
    int r = $urandom_range(1, 5);
    int c = $urandom_range(1, 5);
    int n = r * c;
    int mode = $urandom_range(0, 7);
    int ov = $urandom_range(0, n - 1);
    int p;
    if (mode == 0) begin
      if ($urandom_range(0, 1) == 1) r = 0; else r = $urandom_range(6, 9);
    end
    if ($urandom_range(0, 3) == 0) s = sep_str();
    s = {s, num_str(r), sep_str(), num_str(c), sep_str()};
    for (int e = 0; e < n; e++) begin
      if (mode == 1 && e == ov) s = {s, num_str($urandom_range(256, 999)), sep_str()};
      else s = {s, num_str($urandom_range(0, 255)), sep_str()};
    end
    if (mode == 2) begin
      p = $urandom_range(1, s.len() - 1);
      s = {s.substr(0, p - 1), $sformatf("%c", bad[$urandom_range(0, 6)]), s.substr(p, s.len() - 1)};
    end
    return s;
  endfunction

  initial begin
    wr_exp_t w;
    res_exp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_en) begin
          if (wq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got addr %0d data %0d, required no write", wr_addr, wr_data);
          end else begin
            w = wq.pop_front();
            check("wr_addr", wr_addr, w.addr);
            check("wr_data", wr_data, w.data);
            check("wr_timing", cyc, strobe_cyc[w.bidx] + 1);
            check("busy_at_write", busy, 1);
          end
        end
        if (done || error) begin
          if (rq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_result: got done %0d error %0d, required none", done, error);
          end else begin
            r = rq.pop_front();
            check("result_kind", {done, error}, r.is_err ? 1 : 2);
            check("err_code", err_code, r.code);
            check("busy_at_result", busy, 0);
            check("result_timing", cyc, strobe_cyc[r.bidx] + r.delay);
            if (!r.is_err) begin
              check("rows", rows, r.r);
              check("cols", cols, r.c);
            end
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; uart_rx_done = 1'b0; uart_rx_data = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", {wr_en, wr_addr, wr_data, rows, cols, busy, done, error, err_code}, 0);
    tick();
    rst = 1'b0;
    tick();

    run_case("2 3 1 2 3 4 5 6\n", 1'b0);
    run_case("  1\015\0121,\015\012255\015\012", 1'b0);
    run_case("6 2 ", 1'b0);
    run_case("0 1 ", 1'b0);
    run_case("1 1 256 ", 1'b0);
    run_case("2 2 7 x", 1'b0);
    // A byte strobed together with start must not reach the parser.
    run_case("1 1 5 ", 1'b1);
    run_case("5 5 0 1 2 3 4 5 6 7 8 9 10 11 12 13 14 15 16 17 18 19 20 21 22 23 024 ", 1'b0);

    // Reset in the middle of a 2x2 parse after two elements.
    model("2 2 1 2 ");
    do_start(1'b0, 8'h00);
    send_str("2 2 1 2 ");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("reset_mid_parse", {wr_en, wr_addr, wr_data, rows, cols, busy, done, error, err_code}, 0);
    tick();
    rst = 1'b0;
    send_str("3 4 ");
    wait_drain();

    for (int t = 0; t < 40; t++) run_case(gen_case(), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
